// File: rtl/data_mem_responder_if.sv
// Load/store request and response channel between an initiator (master)
// and the data memory responder (slave).
interface data_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory behind a valid/ready load/store channel,
// with a fixed number of wait states between acceptance and access.
module data_mem_responder #(
   parameter int DEPTH       = 64,
   parameter int WAIT_STATES = 2
) (
   input logic                 clk,
   input logic                 rst,
   data_mem_responder_if.slave bus
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   logic [31:0] mem [DEPTH];

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [AW-1:0] idx;
   logic          acc_err;
   logic          access;
   logic          wr_en;

   // DEPTH is a power of two, so "word index >= DEPTH" reduces to any upper bit set.
   always_comb begin
      idx     = addr_q[AW+1:2];
      acc_err = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0);
      access  = (state_q == S_WAIT) && (cnt_q == 4'd0);
      wr_en   = access && we_q && !acc_err;
   end

   // NOTE: every output of this block gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               we_d    = bus.req_we;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               be_d    = bus.req_be;
               cnt_d   = 4'(WAIT_STATES);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               err_d   = acc_err;
               rdata_d = (acc_err || we_q) ? 32'h0 : mem[idx];
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (bus.resp_ready) begin
               rdata_d = 32'h0;
               err_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         be_q    <= 4'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // NOTE: storage has no reset; contents survive rst and map onto plain RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (be_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

   assign bus.req_ready  = (state_q == S_IDLE) && rst;
   assign bus.resp_valid = (state_q == S_RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: default build (WAIT_STATES=2) plus a WAIT_STATES=0 build
// for back-to-back throughput.
module tb_data_mem_responder;

   localparam int DEPTH = 64;
   localparam int WS    = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   data_mem_responder_if m_if ();
   data_mem_responder_if z_if ();

   data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (m_if)
   );

   data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut_ws0 (
      .clk (clk),
      .rst (rst),
      .bus (z_if)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called #1 after an edge with the DUT idle and resp_ready=1.
   task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input logic [31:0] exp_rdata,
                      input logic exp_err, input string tag);
      int n;
      m_if.req_valid = 1'b1;
      m_if.req_we    = we;
      m_if.req_addr  = addr;
      m_if.req_wdata = wdata;
      m_if.req_be    = be;
      @(posedge clk); #1;
      m_if.req_valid = 1'b0;
      m_if.req_we    = 1'b0;
      n = 0;
      while (!m_if.resp_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, " latency"}, 32'(n), 32'(WS + 1));
      check({tag, " rdata"}, m_if.resp_rdata, exp_rdata);
      check({tag, " err"}, 32'(m_if.resp_err), 32'(exp_err));
      @(posedge clk); #1;
      check({tag, " back to idle"}, 32'(m_if.req_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      m_if.req_valid = 1'b0; m_if.req_we = 1'b0; m_if.req_addr = 32'h0;
      m_if.req_wdata = 32'h0; m_if.req_be = 4'h0; m_if.resp_ready = 1'b1;
      z_if.req_valid = 1'b0; z_if.req_we = 1'b0; z_if.req_addr = 32'h0;
      z_if.req_wdata = 32'h0; z_if.req_be = 4'h0; z_if.resp_ready = 1'b1;

      // Reset state
      #1 rst = 1'b0;
      #2;
      check("rst req_ready", 32'(m_if.req_ready), 32'd0);
      check("rst resp_valid", 32'(m_if.resp_valid), 32'd0);
      check("rst resp_rdata", m_if.resp_rdata, 32'h0);
      check("rst resp_err", 32'(m_if.resp_err), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      #1 check("post rst req_ready", 32'(m_if.req_ready), 32'd1);
      @(posedge clk); #1;

      // Full-word store/load and byte-enable merge
      txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, "st 0x10");
      txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "ld 0x10");
      txn(1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0, "st 0x20");
      txn(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0, "st 0x20 be0101");
      txn(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, "ld 0x20 merged");

      // Error cases leave storage untouched; be=0000 store is a no-op
      txn(1'b0, 32'h22, 32'h0, 4'h0, 32'h0, 1'b1, "ld misaligned");
      txn(1'b0, 32'(DEPTH * 4), 32'h0, 4'h0, 32'h0, 1'b1, "ld out of range");
      txn(1'b1, 32'h21, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, "st misaligned");
      txn(1'b1, 32'(DEPTH * 4 + 32), 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, "st out of range");
      txn(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, "ld 0x20 after errs");
      txn(1'b1, 32'h10, 32'h00000000, 4'h0, 32'h0, 1'b0, "st be0000");
      txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "ld 0x10 after be0000");

      // Response back-pressure; request inputs toggled meanwhile must be ignored
      m_if.resp_ready = 1'b0;
      m_if.req_valid = 1'b1; m_if.req_we = 1'b0; m_if.req_addr = 32'h20;
      @(posedge clk); #1;
      m_if.req_we = 1'b1; m_if.req_addr = 32'h10; m_if.req_wdata = 32'h0; m_if.req_be = 4'hF;
      begin
         int n = 0;
         while (!m_if.resp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
         end
         check("hold latency", 32'(n), 32'(WS + 1));
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check($sformatf("hold%0d resp_valid", i), 32'(m_if.resp_valid), 32'd1);
         check($sformatf("hold%0d rdata", i), m_if.resp_rdata, 32'h11BB33DD);
         check($sformatf("hold%0d err", i), 32'(m_if.resp_err), 32'd0);
         check($sformatf("hold%0d req_ready", i), 32'(m_if.req_ready), 32'd0);
      end
      m_if.req_valid = 1'b0; m_if.req_we = 1'b0;
      m_if.resp_ready = 1'b1;
      @(posedge clk); #1;
      check("release resp_valid", 32'(m_if.resp_valid), 32'd0);
      check("release req_ready", 32'(m_if.req_ready), 32'd1);
      txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "ld 0x10 after ignored st");

      // Asynchronous reset while a response is held
      m_if.resp_ready = 1'b0;
      m_if.req_valid = 1'b1; m_if.req_we = 1'b0; m_if.req_addr = 32'h10;
      @(posedge clk); #1;
      m_if.req_valid = 1'b0;
      repeat (WS + 2) @(posedge clk);
      #1 check("pre-rst resp_rdata", m_if.resp_rdata, 32'hDEADBEEF);
      @(negedge clk); #1 rst = 1'b0;
      #1;
      check("async rst resp_valid", 32'(m_if.resp_valid), 32'd0);
      check("async rst resp_rdata", m_if.resp_rdata, 32'h0);
      check("async rst req_ready", 32'(m_if.req_ready), 32'd0);
      @(negedge clk); rst = 1'b1; m_if.resp_ready = 1'b1;
      @(posedge clk); #1;

      // Reset mid-WAIT aborts the pending store
      txn(1'b1, 32'h30, 32'h00000000, 4'hF, 32'h0, 1'b0, "st 0x30 zero");
      m_if.req_valid = 1'b1; m_if.req_we = 1'b1; m_if.req_addr = 32'h30;
      m_if.req_wdata = 32'hCAFEF00D; m_if.req_be = 4'hF;
      @(posedge clk); #1;
      m_if.req_valid = 1'b0; m_if.req_we = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("wait rst resp_valid", 32'(m_if.resp_valid), 32'd0);
      check("wait rst resp_rdata", m_if.resp_rdata, 32'h0);
      check("wait rst resp_err", 32'(m_if.resp_err), 32'd0);
      check("wait rst req_ready", 32'(m_if.req_ready), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      txn(1'b0, 32'h30, 32'h0, 4'h0, 32'h00000000, 1'b0, "ld 0x30 after abort");
      txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "ld 0x10 survives rst");

      // WAIT_STATES=0 build: back-to-back, one response every 3 cycles
      z_if.req_valid = 1'b1; z_if.req_we = 1'b1; z_if.req_addr = 32'h4;
      z_if.req_wdata = 32'h5A5A1234; z_if.req_be = 4'hF;
      begin
         logic [5:0] exp_rv;
         logic [5:0] exp_rr;
         exp_rv = 6'b010010;
         exp_rr = 6'b100100;
         for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check($sformatf("ws0 e%0d resp_valid", k), 32'(z_if.resp_valid), 32'(exp_rv[k]));
            check($sformatf("ws0 e%0d req_ready", k), 32'(z_if.req_ready), 32'(exp_rr[k]));
            if (k == 0) begin
               z_if.req_we = 1'b0; z_if.req_wdata = 32'h0;
            end
            if (k == 1) check("ws0 store rdata", z_if.resp_rdata, 32'h0);
            if (k == 4) begin
               check("ws0 load rdata", z_if.resp_rdata, 32'h5A5A1234);
               check("ws0 load err", 32'(z_if.resp_err), 32'd0);
               z_if.req_valid = 1'b0;
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
